// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: periodic masked ADC scan sequencer with a tagged FWFT result FIFO
// Ports: wb_clk_i/wb_rst_i clock and sync active-high reset; seq_en, chan_mask, period, clr_err scan control;
// adc_start/adc_chan/adc_eoc/adc_data ADC handshake; res_valid/res_ready/res_data/res_chan result read port;
// busy, overflow, timeout_err status. Define SEQ_TIMEOUT_EN to abort conversions after TIMEOUT cycles.
module adc_conv_sequencer #(
  parameter int DATA_W     = 10,
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        seq_en,
  input  logic [CHANNELS-1:0]         chan_mask,
  input  logic [15:0]                 period,
  input  logic                        clr_err,
  output logic                        adc_start,
  output logic [$clog2(CHANNELS)-1:0] adc_chan,
  input  logic                        adc_eoc,
  input  logic [DATA_W-1:0]           adc_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_W-1:0]           res_data,
  output logic [$clog2(CHANNELS)-1:0] res_chan,
  output logic                        busy,
  output logic                        overflow,
  output logic                        timeout_err
);
  localparam int CW = $clog2(CHANNELS);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (CHANNELS < 2 || FIFO_DEPTH < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("adc_conv_sequencer: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, START, CONVERT, NEXT} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic pend_q, pend_d, tick, take;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CW-1:0] chan_q, chan_d, low_idx, nxt_idx;
  logic low_found, nxt_found;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW+DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic push, pop, full, accept, ovf_q, ovf_d, tmo_hit;
  // Compare as >= so shrinking period below the running count still wraps promptly; period 0 ticks every cycle.
  assign tick   = seq_en && ({1'b0, cnt_q} + 17'd1 >= {1'b0, period});
  assign cnt_d  = (!seq_en || tick) ? '0 : cnt_q + 16'd1;
  assign take   = state_q == IDLE && pend_q && seq_en;
  // A tick coinciding with consumption re-arms pending, so period 0 gives back-to-back scans.
  assign pend_d = tick | (pend_q & ~take);
  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (chan_mask[i]) begin
        low_found = 1'b1;
        low_idx   = CW'(i);
      end
      if (mask_q[i] && CW'(i) > chan_q) begin
        nxt_found = 1'b1;
        nxt_idx   = CW'(i);
      end
    end
  end
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic tmo_q, tmo_d;
  assign tcnt_d      = state_q == CONVERT ? tcnt_q + 1'b1 : '0;
  // A late eoc in the final allowed cycle still counts as a completed conversion.
  assign tmo_hit     = state_q == CONVERT && !adc_eoc && tcnt_q == TW'(TIMEOUT - 1);
  assign tmo_d       = tmo_hit ? 1'b1 : clr_err ? 1'b0 : tmo_q;
  assign timeout_err = tmo_q;
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_d;
    end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    chan_d  = chan_q;
    case (state_q)
      IDLE: if (take) begin
        mask_d  = chan_mask;
        chan_d  = low_found ? low_idx : chan_q;
        state_d = low_found ? START : IDLE;
      end
      START:   state_d = CONVERT;
      CONVERT: state_d = (adc_eoc || tmo_hit) ? NEXT : CONVERT;
      NEXT: begin
        state_d = (nxt_found && seq_en) ? START : IDLE;
        chan_d  = (nxt_found && seq_en) ? nxt_idx : chan_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign push      = state_q == CONVERT && adc_eoc;
  assign pop       = res_valid && res_ready;
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // A pop in the same cycle frees the head slot, so a push to a full FIFO is still accepted.
  assign accept    = push && (!full || pop);
  assign wr_d      = wr_q + (AW+1)'(accept);
  assign rd_d      = rd_q + (AW+1)'(pop);
  assign ovf_d     = (push && !accept) ? 1'b1 : clr_err ? 1'b0 : ovf_q;
  assign res_valid = wr_q != rd_q;
  assign {res_chan, res_data} = res_valid ? mem_q[rd_q[AW-1:0]] : '0;
  assign adc_start = state_q == START;
  assign adc_chan  = chan_q;
  assign busy      = state_q != IDLE;
  assign overflow  = ovf_q;
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      mask_q  <= '0;
      chan_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      chan_q  <= chan_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  always_ff @(posedge wb_clk_i)
    if (accept) mem_q[wr_q[AW-1:0]] <= {chan_q, adc_data};
endmodule

// File: tb/tb_adc_conv_sequencer.sv
// tb_adc_conv_sequencer: scoreboard bench for adc_conv_sequencer (directed scans, FIFO edges, reset, optional timeout)
module tb_adc_conv_sequencer;
`ifdef SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif
  logic wb_clk_i = 0, wb_rst_i = 1, seq_en = 0, clr_err = 0, adc_eoc = 0, res_ready = 0;
  logic [3:0] chan_mask = '0;
  logic [15:0] period = '0;
  logic [9:0] adc_data = '0;
  logic adc_start, res_valid, busy, overflow, timeout_err;
  logic [1:0] adc_chan, res_chan;
  logic [9:0] res_data;
  int checks = 0, errors = 0, n;
  logic [11:0] expq[$];
  adc_conv_sequencer #(.DATA_W(10), .CHANNELS(4), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .seq_en(seq_en), .chan_mask(chan_mask), .period(period),
    .clr_err(clr_err), .adc_start(adc_start), .adc_chan(adc_chan), .adc_eoc(adc_eoc), .adc_data(adc_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_chan(res_chan), .busy(busy),
    .overflow(overflow), .timeout_err(timeout_err)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: every accepted head entry must match the oldest expected result.
  always @(negedge wb_clk_i)
    if (!wb_rst_i && res_valid && res_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_extra got %0h expected no entry", {res_chan, res_data});
      end else check("pop_entry", 32'({res_chan, res_data}), 32'(expq.pop_front()));
    end
  task automatic chk_zero(input string tag);
    check({tag, "_start"}, 32'(adc_start), 0);
    check({tag, "_chan"}, 32'(adc_chan), 0);
    check({tag, "_valid"}, 32'(res_valid), 0);
    check({tag, "_rdata"}, 32'({res_chan, res_data}), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_tmo"}, 32'(timeout_err), 0);
  endtask
  task automatic wait_start(input logic [1:0] ch, output int cnt);
    bit ok;
    ok = 0;
    cnt = 0;
    while (!ok && cnt < 300) begin
      @(negedge wb_clk_i);
      cnt++;
      ok = adc_start;
    end
    check("start_seen", 32'(ok), 1);
    check("start_chan", 32'(adc_chan), 32'(ch));
  endtask
  task automatic conv(input logic [1:0] ch, input int d, input logic [9:0] dat, input bit keep,
                      input bit rdy, input bit clr, input bit drop, output int cnt);
    logic old;
    wait_start(ch, cnt);
    repeat (d) @(posedge wb_clk_i);
    #1;
    old = res_ready;
    adc_eoc = 1;
    adc_data = dat;
    res_ready = old | rdy;
    clr_err = clr;
    if (drop) seq_en = 0;
    if (keep) expq.push_back({ch, dat});
    @(negedge wb_clk_i);
    check("eoc_chan", 32'(adc_chan), 32'(ch));
    @(posedge wb_clk_i);
    #1;
    adc_eoc = 0;
    clr_err = 0;
    res_ready = old;
  endtask
  task automatic drain();
    bit done;
    done = 0;
    @(posedge wb_clk_i);
    #1 res_ready = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge wb_clk_i);
      done = !res_valid;
    end
    res_ready = 0;
    check("drain_empty", 32'(done), 1);
    check("queue_empty", 32'(expq.size()), 0);
  endtask
  task automatic quiet(input string tag);
    bit bad;
    bad = 0;
    repeat (30) begin
      @(negedge wb_clk_i);
      bad |= adc_start;
    end
    check({tag, "_no_start"}, 32'(bad), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge wb_clk_i);
    chk_zero("reset");
    // Single scan: mask 0101, period 20, 5-cycle conversions.
    period = 20;
    chan_mask = 4'b0101;
    @(posedge wb_clk_i);
    #1 wb_rst_i = 0;
    seq_en = 1;
    conv(2'd0, 5, 10'h155, 1, 0, 0, 0, n);
    check("first_start_latency", 32'(n), 22);
    @(negedge wb_clk_i);
    check("valid_after_eoc", 32'(res_valid), 1);
    check("fwft_head", 32'({res_chan, res_data}), 32'({2'd0, 10'h155}));
    check("next_gap_start", 32'(adc_start), 0);
    check("next_gap_busy", 32'(busy), 1);
    conv(2'd2, 5, 10'h2AA, 1, 0, 0, 1, n);
    check("second_start_gap", 32'(n), 1);
    repeat (3) @(negedge wb_clk_i);
    check("scan_done_busy", 32'(busy), 0);
    drain();
    // Overflow: two full scans into a 4-entry FIFO, clr_err racing a set.
    period = 0;
    chan_mask = 4'b1111;
    seq_en = 1;
    for (int k = 0; k < 8; k++) begin
      conv(2'(k % 4), 2, 10'(10'h100 + k), k < 4, 0, k == 5, k == 7, n);
      if (k == 3) check("ovf_before_full", 32'(overflow), 0);
      if (k == 4) check("ovf_set", 32'(overflow), 1);
      if (k == 5) check("ovf_set_beats_clr", 32'(overflow), 1);
    end
    @(posedge wb_clk_i);
    #1 clr_err = 1;
    @(posedge wb_clk_i);
    #1 clr_err = 0;
    check("ovf_cleared", 32'(overflow), 0);
    drain();
    // Full FIFO with a pop in the eoc cycle: push accepted, no overflow.
    seq_en = 1;
    for (int k = 0; k < 5; k++) conv(2'(k % 4), 1, 10'(10'h200 + k), 1, k == 4, 0, k == 4, n);
    check("full_pop_no_ovf", 32'(overflow), 0);
    repeat (3) @(negedge wb_clk_i);
    check("full_pop_busy", 32'(busy), 0);
    drain();
    // Empty mask never starts a conversion.
    chan_mask = 4'b0000;
    seq_en = 1;
    quiet("empty_mask");
    seq_en = 0;
    // seq_en dropped during channel 1 of mask 0111: channel 2 never starts.
    @(posedge wb_clk_i);
    #1 chan_mask = 4'b0111;
    res_ready = 1;
    seq_en = 1;
    conv(2'd0, 3, 10'h0F0, 1, 0, 0, 0, n);
    conv(2'd1, 3, 10'h00F, 1, 0, 0, 1, n);
    quiet("seq_drop");
    @(posedge wb_clk_i);
    #1 res_ready = 0;
    drain();
    // Reset mid-conversion flushes the FIFO; a late eoc is ignored.
    chan_mask = 4'b0011;
    seq_en = 1;
    conv(2'd0, 2, 10'h3C3, 1, 0, 0, 0, n);
    wait_start(2'd1, n);
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1;
    seq_en = 0;
    @(posedge wb_clk_i);
    #1 wb_rst_i = 0;
    adc_eoc = 1;
    adc_data = 10'h1E1;
    expq.delete();
    @(negedge wb_clk_i);
    chk_zero("rst_mid");
    @(posedge wb_clk_i);
    #1 adc_eoc = 0;
    @(negedge wb_clk_i);
    chk_zero("late_eoc");
`ifdef SEQ_TIMEOUT_EN
    // Channel 1 never answers: abort after TIMEOUT CONVERT cycles.
    chan_mask = 4'b0011;
    seq_en = 1;
    conv(2'd0, 2, 10'h0AB, 1, 0, 0, 0, n);
    wait_start(2'd1, n);
    seq_en = 0;
    n = 0;
    while (!timeout_err && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("tmo_cycles", 32'(n), 17);
    repeat (2) @(negedge wb_clk_i);
    check("tmo_idle", 32'(busy), 0);
    drain();
    @(posedge wb_clk_i);
    #1 clr_err = 1;
    @(posedge wb_clk_i);
    #1 clr_err = 0;
    check("tmo_cleared", 32'(timeout_err), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
